level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
- Game-flow controller that produces the current level number `levelState`, consumed by the on-screen level digit display and the bubble/level loaders.
- Tracks level progression, player lives, and inter-level/post-hit pauses timed in video frames.
- Issues a one-cycle `loadLevel` strobe whenever the playfield must be (re)initialised.
- Sits between game-event detectors (collision, bubble-count logic, keypad) and all level-dependent drawing/motion blocks.

Parameters:
- MAX_LEVEL, 12, last playable level (1..15); clearing it ends the game as won.
- LIVES, 3, lives at game start (1..15).
- CLEAR_FRAMES, 120, frames of pause after a level is cleared (1..255).
- HIT_FRAMES, 90, frames of pause after the player is hit (1..255).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse once per video frame.
- startBtn  in  1  level-sensitive start key, synchronous to clk.
- levelCleared  in  1  one-cycle pulse: all bubbles of the current level popped.
- playerHit  in  1  one-cycle pulse: player collided with a bubble.
- levelState  out  4  current level number, 1..MAX_LEVEL.
- livesLeft  out  4  remaining lives.
- loadLevel  out  1  one-cycle strobe: reinitialise playfield for `levelState`.
- gameActive  out  1  high only in PLAY.
- freeze  out  1  high in CLEAR_WAIT and HIT_WAIT; motion blocks hold position.
- gameOver  out  1  high in OVER.
- gameWon  out  1  high in WIN.

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE, levelState=1, livesLeft=LIVES, frameCnt=0, startPrev=0.
  - All 1-bit outputs 0.
- Start edge:
  - startPrev registers startBtn every cycle.
  - startEdge = startBtn & ~startPrev.
  - A held key produces exactly one edge.
- Outputs are registered and decoded from state; `loadLevel` is high only during the single LOAD cycle.
- IDLE:
  - startEdge -> LOAD; same cycle sets levelState=1, livesLeft=LIVES.
- LOAD (1 cycle):
  - loadLevel=1, then unconditionally -> PLAY.
  - frameCnt cleared.
- PLAY:
  - levelCleared=1 -> CLEAR_WAIT, frameCnt=0. If levelCleared and playerHit arrive in the same cycle, clear wins and the hit is ignored.
  - else playerHit=1 and livesLeft==1 -> livesLeft=0, go to OVER.
  - else playerHit=1 -> livesLeft-1, go to HIT_WAIT, frameCnt=0.
- CLEAR_WAIT:
  - frameCnt increments on each startOfFrame.
  - On the startOfFrame where frameCnt==CLEAR_FRAMES-1:
    - if levelState==MAX_LEVEL -> WIN, levelState unchanged;
    - else levelState+1 -> LOAD.
- HIT_WAIT:
  - Same counting, ending at HIT_FRAMES-1, then -> LOAD with the same levelState (level restarts).
- OVER, WIN:
  - Hold all counters.
  - startEdge -> LOAD with levelState=1, livesLeft=LIVES (new game).
- Event pulses outside PLAY (levelCleared, playerHit) are ignored in all other states.
- startEdge is ignored in LOAD, PLAY, CLEAR_WAIT and HIT_WAIT.
- frameCnt is 8 bits and never wraps: it is cleared on entry to each wait state. startOfFrame outside wait states does not change it.
- levelState never exceeds MAX_LEVEL and never reads 0 after reset.
- Reset asserted mid-wait or mid-LOAD returns immediately to IDLE values; no `loadLevel` pulse is emitted.
- Unused state encodings -> IDLE.

Test Plan:
- Reset, startBtn held high 10 cycles -> exactly one `loadLevel` pulse, levelState=1, livesLeft=3, gameActive=1 on the cycle after LOAD.
- In PLAY, pulse levelCleared, then 120 startOfFrame pulses -> freeze=1 throughout; `loadLevel` on the cycle after the 120th pulse; levelState=2.
- LIVES=3: three playerHit pulses, each separated by 90 frames -> livesLeft 2, then 1, then 0. The first two hits reload the same level; the third gives gameOver=1 with no freeze.
- Simultaneous levelCleared and playerHit in PLAY -> CLEAR_WAIT entered, livesLeft unchanged.
- MAX_LEVEL=12, levelState=12, levelCleared, then 120 frames -> gameWon=1, levelState stays 12. A startBtn edge then gives loadLevel, levelState=1, livesLeft=3.
- resetN low during CLEAR_WAIT frame 50 -> all outputs return to reset values asynchronously; no loadLevel after release until a startBtn edge.

Source files
------------

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM tracking level, lives and frame-timed pauses
module level_sequencer #(
  parameter int MAX_LEVEL    = 12,
  parameter int LIVES        = 3,
  parameter int CLEAR_FRAMES = 120,
  parameter int HIT_FRAMES   = 90
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startBtn,
  input  logic       levelCleared,
  input  logic       playerHit,
  output logic [3:0] levelState,
  output logic [3:0] livesLeft,
  output logic       loadLevel,
  output logic       gameActive,
  output logic       freeze,
  output logic       gameOver,
  output logic       gameWon
);
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, CLEAR_WAIT, HIT_WAIT, OVER, WIN} state_t;
  localparam logic [3:0] MAX_LVL   = 4'(MAX_LEVEL);
  localparam logic [3:0] LIVES_INI = 4'(LIVES);
  localparam logic [7:0] CLR_END   = 8'(CLEAR_FRAMES - 1);
  localparam logic [7:0] HIT_END   = 8'(HIT_FRAMES - 1);
  state_t state, state_nxt;
  logic [3:0] level_nxt, lives_nxt;
  logic [7:0] frame_cnt, cnt_nxt;
  logic start_prev, start_edge, wait_end;
  assign start_edge = startBtn & ~start_prev;
  assign wait_end = startOfFrame && frame_cnt == (state == CLEAR_WAIT ? CLR_END : HIT_END);
  always_comb begin
    state_nxt = state;
    level_nxt = levelState;
    lives_nxt = livesLeft;
    cnt_nxt = frame_cnt;
    case (state)
      IDLE, OVER, WIN: if (start_edge) begin
        state_nxt = LOAD;
        level_nxt = 4'd1;
        lives_nxt = LIVES_INI;
      end
      LOAD: begin
        state_nxt = PLAY;
        cnt_nxt = 8'd0;
      end
      PLAY: if (levelCleared) begin
        state_nxt = CLEAR_WAIT;
        cnt_nxt = 8'd0;
      end else if (playerHit) begin
        lives_nxt = livesLeft - 4'd1;
        state_nxt = livesLeft == 4'd1 ? OVER : HIT_WAIT;
        cnt_nxt = 8'd0;
      end
      CLEAR_WAIT, HIT_WAIT: if (wait_end) begin
        state_nxt = (state == CLEAR_WAIT && levelState == MAX_LVL) ? WIN : LOAD;
        level_nxt = (state == CLEAR_WAIT && levelState != MAX_LVL) ? levelState + 4'd1 : levelState;
      end else if (startOfFrame) cnt_nxt = frame_cnt + 8'd1;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      levelState <= 4'd1;
      livesLeft <= LIVES_INI;
      frame_cnt <= 8'd0;
      start_prev <= 1'b0;
    end else begin
      state <= state_nxt;
      levelState <= level_nxt;
      livesLeft <= lives_nxt;
      frame_cnt <= cnt_nxt;
      start_prev <= startBtn;
    end
  assign loadLevel = state == LOAD;
  assign gameActive = state == PLAY;
  assign freeze = state == CLEAR_WAIT || state == HIT_WAIT;
  assign gameOver = state == OVER;
  assign gameWon = state == WIN;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed checks of level flow, lives, pauses and reset
module tb_level_sequencer;
  logic clk = 0, resetN = 0, startOfFrame = 0, startBtn = 0, levelCleared = 0, playerHit = 0;
  logic [3:0] levelState, livesLeft;
  logic loadLevel, gameActive, freeze, gameOver, gameWon;
  int checks = 0, errors = 0, bad = 0, loads = 0;

  level_sequencer dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startBtn(startBtn),
    .levelCleared(levelCleared), .playerHit(playerHit), .levelState(levelState),
    .livesLeft(livesLeft), .loadLevel(loadLevel), .gameActive(gameActive),
    .freeze(freeze), .gameOver(gameOver), .gameWon(gameWon)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n frame pulses; freeze must hold until the last one lands
  task automatic run_frames(input int n);
    bad = 0;
    for (int k = 1; k <= n; k++) begin
      startOfFrame = 1;
      tick();
      startOfFrame = 0;
      if (k < n) begin
        if (!freeze || loadLevel) bad++;
        tick();
        if (!freeze || loadLevel) bad++;
      end
    end
    chk("freeze_hold", bad, 0);
  endtask

  task automatic clear_level(input logic [3:0] next_lvl);
    levelCleared = 1;
    tick();
    levelCleared = 0;
    run_frames(120);
    chk("clr_load", loadLevel, 1);
    chk("clr_level", levelState, next_lvl);
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_level", levelState, 1);
    chk("rst_lives", livesLeft, 3);
    chk("rst_flags", {loadLevel, gameActive, freeze, gameOver, gameWon}, 0);
    resetN = 1;
    tick();
    chk("idle_noload", loadLevel, 0);

    startBtn = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (loadLevel) loads++;
      if (i == 0) chk("start_load", loadLevel, 1);
      if (i == 1) chk("start_active", gameActive, 1);
    end
    chk("start_one_pulse", loads, 1);
    chk("start_level", levelState, 1);
    chk("start_lives", livesLeft, 3);
    startBtn = 0;

    levelCleared = 1;
    tick();
    levelCleared = 0;
    chk("clr_freeze", freeze, 1);
    chk("clr_inactive", gameActive, 0);
    run_frames(120);
    chk("clr_load", loadLevel, 1);
    chk("clr_level2", levelState, 2);
    tick();
    chk("clr_play", gameActive, 1);

    for (int h = 2; h >= 1; h--) begin
      playerHit = 1;
      tick();
      playerHit = 0;
      chk("hit_lives", livesLeft, 4'(h));
      chk("hit_freeze", freeze, 1);
      run_frames(90);
      chk("hit_reload", loadLevel, 1);
      chk("hit_same_level", levelState, 2);
      tick();
    end
    playerHit = 1;
    tick();
    playerHit = 0;
    chk("over_lives", livesLeft, 0);
    chk("over_flag", gameOver, 1);
    chk("over_nofreeze", freeze, 0);
    levelCleared = 1;
    startOfFrame = 1;
    tick();
    levelCleared = 0;
    startOfFrame = 0;
    chk("over_ignores", {gameOver, loadLevel, livesLeft}, {1'b1, 1'b0, 4'd0});

    startBtn = 1;
    tick();
    startBtn = 0;
    chk("over_restart_load", loadLevel, 1);
    chk("over_restart_lvl", {levelState, livesLeft}, {4'd1, 4'd3});
    tick();

    levelCleared = 1;
    playerHit = 1;
    tick();
    levelCleared = 0;
    playerHit = 0;
    chk("simul_freeze", freeze, 1);
    chk("simul_lives", livesLeft, 3);
    run_frames(120);
    chk("simul_load", loadLevel, 1);
    chk("simul_level", levelState, 2);
    tick();

    for (int l = 3; l <= 12; l++) clear_level(4'(l));
    chk("lvl12", levelState, 12);
    startBtn = 1;
    tick();
    startBtn = 0;
    chk("play_ignores_start", {gameActive, loadLevel}, 2'b10);
    levelCleared = 1;
    tick();
    levelCleared = 0;
    run_frames(120);
    chk("win_flag", gameWon, 1);
    chk("win_noload", loadLevel, 0);
    chk("win_level", levelState, 12);
    tick();
    chk("win_hold", {gameWon, levelState}, {1'b1, 4'd12});
    startBtn = 1;
    tick();
    startBtn = 0;
    chk("win_restart_load", loadLevel, 1);
    chk("win_restart_lvl", {levelState, livesLeft}, {4'd1, 4'd3});
    tick();

    clear_level(4'd2);
    playerHit = 1;
    tick();
    playerHit = 0;
    run_frames(90);
    tick();
    levelCleared = 1;
    tick();
    levelCleared = 0;
    chk("pre_rst_state", {levelState, livesLeft, freeze}, {4'd2, 4'd2, 1'b1});
    run_frames(50);
    #2 resetN = 0;
    #1;
    chk("async_rst_level", levelState, 1);
    chk("async_rst_lives", livesLeft, 3);
    chk("async_rst_flags", {loadLevel, gameActive, freeze, gameOver, gameWon}, 0);
    tick();
    resetN = 1;
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      startOfFrame = i[0];
      tick();
      if (loadLevel) loads++;
    end
    startOfFrame = 0;
    chk("post_rst_noload", loads, 0);
    startBtn = 1;
    tick();
    startBtn = 0;
    chk("post_rst_start", loadLevel, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
